// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// mult_arb_pkg: FSM state encoding and index-width helper for mult_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_e;

  // Index width for m requesters; a single requester still needs one bit.
  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult.sv
`default_nettype none
// ----------------------------------------------------------------------
// mult: iterative shift-and-add unsigned multiplier, N cycles per product
// Revision: 1.0
// ----------------------------------------------------------------------
module mult #(
  parameter int N = 32
) (
  input  logic           reset,
  input  logic           start,
  input  logic           clk,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] O,
  output logic           Finish
);

  localparam int CW = $clog2(N + 1);

  logic           run_q, run_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic           fin_q, fin_d;

  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    fin_d    = fin_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = CW'(N);
      acc_d    = '0;
      mcand_d  = {{N{1'b0}}, A};
      mplier_d = B;
      fin_d    = 1'b0;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      // Finish is a level: it stays high until the next start.
      if (cnt_q == CW'(1)) begin
        run_d = 1'b0;
        fin_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      fin_q    <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      fin_q    <= fin_d;
    end
  end

  assign O      = acc_q;
  assign Finish = fin_q;

endmodule
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------
// rr_pick: combinational round-robin selector starting the search at ptr
// Revision: 1.0
// ----------------------------------------------------------------------
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter int M    = 4,
  parameter int IDXW = idx_w(M)
) (
  input  logic [M-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [M-1:0]    gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < M; k++) begin
      c = int'(ptr) + k;
      if (c >= M) c = c - M;
      if (!found && req[c]) begin
        gnt[c] = 1'b1;
        idx    = IDXW'(c);
        found  = 1'b1;
      end
    end
    any = found;
  end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// mult_arbiter: round-robin front end sharing one mult among M requesters
// Revision: 1.0
// ----------------------------------------------------------------------
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [M-1:0]   req,
  input  logic [M*N-1:0] a_in,
  input  logic [M*N-1:0] b_in,
  output logic [M-1:0]   gnt,
  output logic [M-1:0]   done,
  output logic [2*N-1:0] result,
  output logic           busy
);

  localparam int IDXW = idx_w(M);

  arb_state_e     state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [2*N-1:0]  result_q, result_d;

  logic [M-1:0]    pick_gnt;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic [N-1:0]    a_sel, b_sel;

  logic            mult_rst;
  logic            mult_start;
  logic            mult_fin;
  logic [2*N-1:0]  mult_out;

  assign mult_rst = ~reset;

  rr_pick #(
    .M    (M),
    .IDXW (IDXW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < M; i++) begin
      if (pick_gnt[i]) begin
        a_sel = a_in[i*N +: N];
        b_sel = b_in[i*N +: N];
      end
    end
  end

  mult #(
    .N (N)
  ) u_mult (
    .reset  (mult_rst),
    .start  (mult_start),
    .clk    (clk),
    .A      (a_q),
    .B      (b_q),
    .O      (mult_out),
    .Finish (mult_fin)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    gnt        = '0;
    done       = '0;
    mult_start = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant is gated by reset so it is zero while reset is held.
        if (reset && pick_any) begin
          gnt     = pick_gnt;
          idx_d   = pick_idx;
          a_d     = a_sel;
          b_d     = b_sel;
          ptr_d   = (pick_idx == IDXW'(M - 1)) ? '0 : pick_idx + IDXW'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mult_start = 1'b1;
        state_d    = WAIT_CLR;
      end
      WAIT_CLR: begin
        // Finish may still be high from the previous product.
        if (!mult_fin) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mult_fin) begin
          result_d = mult_out;
          state_d  = RESP;
        end
      end
      RESP: begin
        done[idx_q] = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_mult_arbiter: directed vectors for mult_arbiter (N=8 and N=32 builds)
// Revision: 1.0
// ----------------------------------------------------------------------
module tb_mult_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req8;
  logic [31:0] a8, b8;
  logic [3:0]  gnt8, done8;
  logic [15:0] res8;
  logic        busy8;

  logic [3:0]   req32;
  logic [127:0] a32, b32;
  logic [3:0]   gnt32, done32;
  logic [63:0]  res32;
  logic         busy32;

  mult_arbiter #(.N(8), .M(4)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req8),
    .a_in   (a8),
    .b_in   (b8),
    .gnt    (gnt8),
    .done   (done8),
    .result (res8),
    .busy   (busy8)
  );

  mult_arbiter #(.N(32), .M(4)) u_dut32 (
    .clk    (clk),
    .reset  (reset),
    .req    (req32),
    .a_in   (a32),
    .b_in   (b32),
    .gnt    (gnt32),
    .done   (done32),
    .result (res32),
    .busy   (busy32)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event log of the N=8 instance, sampled on the falling edge.
  int          gq[$], dq[$], gt[$], dt[$];
  logic [15:0] rq[$];
  int          cyc = 0;
  int          overlap = 0;
  int          bad_oh = 0;
  int          busy_drop = 0;
  bit          inflight = 1'b0;

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      inflight <= 1'b0;
    end else begin
      if (inflight && !busy8) busy_drop <= busy_drop + 1;
      if (gnt8 != 4'b0 && done8 != 4'b0) overlap <= overlap + 1;
      if (gnt8 != 4'b0) begin
        if (!$onehot(gnt8)) bad_oh <= bad_oh + 1;
        gq.push_back(oh2i(gnt8));
        gt.push_back(cyc);
        inflight <= 1'b1;
      end
      if (done8 != 4'b0) begin
        if (!$onehot(done8)) bad_oh <= bad_oh + 1;
        dq.push_back(oh2i(done8));
        dt.push_back(cyc);
        rq.push_back(res8);
        inflight <= 1'b0;
      end
    end
  end

  task automatic clr_logs();
    gq.delete(); dq.delete(); gt.delete(); dt.delete(); rq.delete();
  endtask

  // Step cycles until ng grants and nd dones are logged; requesters in
  // 'drop' release req right after their grant edge.
  task automatic run_until(input string tag, input int ng, input int nd,
                           input logic [3:0] drop, input int budget);
    int gp;
    bit met;
    gp  = gq.size();
    met = 1'b0;
    for (int c = 0; c < budget && !met; c++) begin
      @(posedge clk); #1;
      while (gp < gq.size()) begin
        if (drop[gq[gp]]) req8[gq[gp]] = 1'b0;
        gp++;
      end
      met = (gq.size() >= ng) && (dq.size() >= nd);
    end
    check({tag, "_reached"}, 64'(met), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset = 1'b0;
    req8  = 4'b0101;
    a8 = '0; b8 = '0;
    req32 = '0; a32 = '0; b32 = '0;

    // Reset state, with requests pending to check gnt is held low
    repeat (3) @(negedge clk);
    check("rst_gnt",    64'(gnt8),  64'd0);
    check("rst_done",   64'(done8), 64'd0);
    check("rst_result", 64'(res8),  64'd0);
    check("rst_busy",   64'(busy8), 64'd0);
    check("rst_res32",  res32,      64'd0);
    req8 = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: N=32 single product
    req32 = 4'b0001;
    a32[31:0] = 32'd24221;
    b32[31:0] = 32'd14867;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (gnt32 != 4'b0) begin
        got = 1'b1;
        check("t1_gnt", 64'(gnt32), 64'd1);
      end
    end
    check("t1_gnt_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    req32 = 4'b0000;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (done32 != 4'b0) begin
        got = 1'b1;
        check("t1_done",   64'(done32), 64'd1);
        check("t1_result", res32,       64'd360093607);
      end
    end
    check("t1_done_seen", 64'(got), 64'd1);

    // 2: four simultaneous requesters served 0,1,2,3
    clr_logs();
    a8 = {4{8'd61}};
    b8 = {4{8'd26}};
    req8 = 4'b1111;
    run_until("t2", 4, 4, 4'b1111, 200);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_gnt%0d", i),  64'(gq[i]), 64'(i));
      check($sformatf("t2_done%0d", i), 64'(dq[i]), 64'(i));
      check($sformatf("t2_res%0d", i),  64'(rq[i]), 64'd1586);
    end

    // 3: pointer moves to 2 after grant 1, so {1,0} request picks 0 first
    clr_logs();
    a8 = {4{8'd6}};
    b8 = {4{8'd6}};
    req8 = 4'b0010;
    run_until("t3a", 1, 1, 4'b1111, 100);
    req8 = 4'b0011;
    run_until("t3b", 3, 3, 4'b1111, 100);
    check("t3_first", 64'(gq[0]), 64'd1);
    check("t3_rr",    64'(gq[1]), 64'd0);
    check("t3_next",  64'(gq[2]), 64'd1);
    check("t3_didx",  64'(dq[1]), 64'd0);
    check("t3_res",   64'(rq[1]), 64'd36);

    // 4: request withdrawn while another op is in flight
    clr_logs();
    a8[7:0] = 8'd200;
    b8[7:0] = 8'd200;
    req8 = 4'b0001;
    run_until("t4a", 1, 0, 4'b1111, 20);
    repeat (2) begin @(posedge clk); #1; end
    a8[23:16] = 8'd3;
    b8[23:16] = 8'd3;
    req8[2] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    req8[2] = 1'b0;
    run_until("t4b", 1, 1, 4'b1111, 50);
    repeat (6) begin @(posedge clk); #1; end
    check("t4_gcount", 64'(gq.size()), 64'd1);
    check("t4_dcount", 64'(dq.size()), 64'd1);
    check("t4_didx",   64'(dq[0]),     64'd0);
    check("t4_res",    64'(rq[0]),     64'd40000);

    // 5: reset during WAIT_DONE, then normal operation with pointer back at 0
    clr_logs();
    a8[15:8] = 8'd100;
    b8[15:8] = 8'd100;
    req8 = 4'b0010;
    run_until("t5a", 1, 0, 4'b1111, 20);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("t5_gnt",    64'(gnt8),  64'd0);
    check("t5_done",   64'(done8), 64'd0);
    check("t5_result", 64'(res8),  64'd0);
    check("t5_busy",   64'(busy8), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    check("t5_nodone", 64'(dq.size()), 64'd0);
    clr_logs();
    a8[15:8]  = 8'd61; b8[15:8]  = 8'd26;
    a8[23:16] = 8'd61; b8[23:16] = 8'd26;
    req8 = 4'b0110;
    run_until("t5b", 2, 2, 4'b1111, 100);
    check("t5_gnt0",  64'(gq[0]), 64'd1);
    check("t5_didx0", 64'(dq[0]), 64'd1);
    check("t5_res0",  64'(rq[0]), 64'd1586);
    check("t5_gnt1",  64'(gq[1]), 64'd2);

    // 6: back-to-back requests from the same client
    clr_logs();
    a8[7:0] = 8'd13;
    b8[7:0] = 8'd17;
    req8 = 4'b0001;
    run_until("t6a", 1, 0, 4'b0000, 20);
    a8[7:0] = 8'd11;
    b8[7:0] = 8'd12;
    run_until("t6b", 2, 2, 4'b0001, 100);
    check("t6_gnt1",  64'(gq[1]), 64'd0);
    check("t6_done0", 64'(dq[0]), 64'd0);
    check("t6_done1", 64'(dq[1]), 64'd0);
    check("t6_res0",  64'(rq[0]), 64'd221);
    check("t6_res1",  64'(rq[1]), 64'd132);
    check("t6_order", 64'(gt[1] > dt[0]), 64'd1);

    // Whole-run properties
    repeat (2) @(posedge clk);
    check("no_overlap",  64'(overlap),   64'd0);
    check("onehot",      64'(bad_oh),    64'd0);
    check("busy_steady", 64'(busy_drop), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
